// File: rtl/fp_div_arbiter_pkg.sv
// Shared types, IEEE-754 constants and operand helpers for the divider
// arbiter and later shared-resource blocks.
package fp_div_arbiter_pkg;

  typedef enum logic {SLOT = 1'b0, WAIT = 1'b1} arb_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;

  localparam int MAX_NREQ = 8;

  // Callers zero-extend their NREQ-wide operand bus to the maximum width.
  function automatic logic [31:0] op_slice(input logic [32*MAX_NREQ-1:0] v, input int i);
    return v[32*i +: 32];
  endfunction

endpackage

// File: rtl/div.sv
// Iterative single-precision divider: samples operands whenever it sits in
// GET, pulses output_z_stb for one cycle, then returns to GET.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  output logic [31:0] output_z,
  output logic        output_z_stb
);
  typedef enum logic [3:0] {GET, UNPACK, SPECIAL, NORM_A, NORM_B, DIVIDE,
                            NORM1, DENORM, ROUND, PACK, PUT} div_state_e;

  div_state_e              st;
  logic [31:0]             a, b, z;
  logic [23:0]             a_m, b_m, z_m;
  logic signed [9:0]       a_e, b_e, z_e, z_eb;
  logic [24:0]             r;
  logic [49:0]             q;
  logic [6:0]              cnt;
  logic                    guard, rnd, sticky;
  logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, z_s;

  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  assign a_zero = (a[30:0] == 31'd0);
  assign b_zero = (b[30:0] == 31'd0);
  assign z_s    = a[31] ^ b[31];
  assign z_eb   = z_e + 10'sd127;

  assign output_z     = z;
  assign output_z_stb = (st == PUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= GET;
      z  <= '0;
    end else begin
      case (st)
        GET: begin
          a  <= input_a;
          b  <= input_b;
          st <= UNPACK;
        end
        UNPACK: begin
          a_m <= {a[30:23] != 8'd0, a[22:0]};
          b_m <= {b[30:23] != 8'd0, b[22:0]};
          a_e <= (a[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, a[30:23]}) - 10'sd127;
          b_e <= (b[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, b[30:23]}) - 10'sd127;
          st  <= SPECIAL;
        end
        SPECIAL: begin
          if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            z  <= 32'hFFC0_0000;
            st <= PUT;
          end else if (a_inf || b_zero) begin
            z  <= {z_s, 8'hFF, 23'd0};
            st <= PUT;
          end else if (a_zero || b_inf) begin
            z  <= {z_s, 31'd0};
            st <= PUT;
          end else begin
            st <= NORM_A;
          end
        end
        NORM_A: begin
          if (!a_m[23]) begin
            a_m <= {a_m[22:0], 1'b0};
            a_e <= a_e - 10'sd1;
          end else st <= NORM_B;
        end
        NORM_B: begin
          if (!b_m[23]) begin
            b_m <= {b_m[22:0], 1'b0};
            b_e <= b_e - 10'sd1;
          end else begin
            r   <= {1'b0, a_m};
            q   <= '0;
            cnt <= '0;
            z_e <= a_e - b_e;
            st  <= DIVIDE;
          end
        end
        // Restoring division, one quotient bit per two cycles (compare, shift).
        DIVIDE: begin
          if (!cnt[0]) begin
            if (r >= {1'b0, b_m}) begin
              r <= r - {1'b0, b_m};
              q <= {q[48:0], 1'b1};
            end else begin
              q <= {q[48:0], 1'b0};
            end
          end else begin
            r <= {r[23:0], 1'b0};
          end
          cnt <= cnt + 7'd1;
          if (cnt == 7'd99) st <= NORM1;
        end
        NORM1: begin
          if (q[49]) begin
            z_m    <= q[49:26];
            guard  <= q[25];
            rnd    <= q[24];
            sticky <= (|q[23:0]) | (|r);
          end else begin
            z_m    <= q[48:25];
            guard  <= q[24];
            rnd    <= q[23];
            sticky <= (|q[22:0]) | (|r);
            z_e    <= z_e - 10'sd1;
          end
          st <= DENORM;
        end
        DENORM: begin
          if (z_e < -10'sd126) begin
            z_m    <= {1'b0, z_m[23:1]};
            guard  <= z_m[0];
            rnd    <= guard;
            sticky <= sticky | rnd;
            z_e    <= z_e + 10'sd1;
          end else st <= ROUND;
        end
        ROUND: begin
          if (guard && (rnd || sticky || z_m[0])) begin
            if (z_m == 24'hFF_FFFF) begin
              z_m <= 24'h80_0000;
              z_e <= z_e + 10'sd1;
            end else z_m <= z_m + 24'd1;
          end
          st <= PACK;
        end
        PACK: begin
          if (z_e > 10'sd127)                  z <= {z_s, 8'hFF, 23'd0};
          else if (z_e == -10'sd126 && !z_m[23]) z <= {z_s, 8'd0, z_m[22:0]};
          else                                 z <= {z_s, z_eb[7:0], z_m[22:0]};
          st <= PUT;
        end
        PUT:     st <= GET;
        default: st <= GET;
      endcase
    end
  end
endmodule

// File: rtl/fp_div_arbiter_rr.sv
// Combinational rotating-priority picker: first set request at or after ptr.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);
  always_comb begin
    int j;
    j        = 0;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        grant_id = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one free-running divider among NREQ requesters: fills each divider
// sample slot with an arbitrated request and routes the quotient back.
module fp_div_arbiter
  import fp_div_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int RR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_z,
  output logic [IDW-1:0]    resp_id,
  output logic              busy
);
  arb_state_e               state, state_nx;
  logic                     owner_valid;
  logic [IDW-1:0]           owner_id, rr_ptr, pick_ptr, win_id;
  logic [NREQ-1:0]          win_oh;
  logic                     win_any;
  logic [32*MAX_NREQ-1:0]   a_wide, b_wide;
  logic [31:0]              slot_a, slot_b, hold_a, hold_b, div_a, div_b, div_z;
  logic                     div_stb;

  assign pick_ptr = (RR != 0) ? rr_ptr : '0;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req      (req_valid),
    .ptr      (pick_ptr),
    .grant    (win_oh),
    .grant_id (win_id),
    .any      (win_any)
  );

  assign a_wide = (32*MAX_NREQ)'(req_a);
  assign b_wide = (32*MAX_NREQ)'(req_b);
  // An empty slot feeds 0/0 so the divider takes its short special-case path.
  assign slot_a = win_any ? op_slice(a_wide, int'(win_id)) : FP_ZERO;
  assign slot_b = win_any ? op_slice(b_wide, int'(win_id)) : FP_ZERO;
  assign div_a  = (state == SLOT) ? slot_a : hold_a;
  assign div_b  = (state == SLOT) ? slot_b : hold_b;

  assign req_ready = (state == SLOT && !rst) ? win_oh : '0;
  assign busy      = (state == WAIT) && owner_valid;

  div u_div (
    .clk          (clk),
    .rst          (rst),
    .input_a      (div_a),
    .input_b      (div_b),
    .output_z     (div_z),
    .output_z_stb (div_stb)
  );

  always_comb begin
    state_nx = state;
    case (state)
      SLOT:    state_nx = WAIT;
      WAIT:    if (div_stb) state_nx = SLOT;
      default: state_nx = SLOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SLOT;
      owner_valid <= 1'b0;
      owner_id    <= '0;
      rr_ptr      <= '0;
      hold_a      <= '0;
      hold_b      <= '0;
      resp_valid  <= '0;
      resp_z      <= '0;
      resp_id     <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= '0;
      if (state == SLOT) begin
        hold_a      <= slot_a;
        hold_b      <= slot_b;
        owner_valid <= win_any;
        if (win_any) begin
          owner_id <= win_id;
          rr_ptr   <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
        end
      end else if (div_stb && owner_valid) begin
        resp_valid <= NREQ'(1) << owner_id;
        resp_z     <= div_z;
        resp_id    <= owner_id;
      end
    end
  end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Randomised scoreboard bench for fp_div_arbiter (RR=1 main instance, RR=0 side instance).
module tb_fp_div_arbiter;
  import fp_div_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, resp_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     resp_z;
  logic [IW-1:0]   resp_id;
  logic            busy;

  logic [N-1:0]    req_valid0, req_ready0, resp_valid0;
  logic [32*N-1:0] req_a0, req_b0;
  logic [31:0]     resp_z0;
  logic [IW-1:0]   resp_id0;
  logic            busy0;

  fp_div_arbiter #(.NREQ(N), .IDW(IW), .RR(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_z(resp_z),
    .resp_id(resp_id), .busy(busy));

  fp_div_arbiter #(.NREQ(N), .IDW(IW), .RR(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_a(req_a0), .req_b(req_b0),
    .req_ready(req_ready0), .resp_valid(resp_valid0), .resp_z(resp_z0),
    .resp_id(resp_id0), .busy(busy0));

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] z; } op_t;
  typedef struct { int id; logic [31:0] z; } exp_t;

  op_t    pend[N][$];
  exp_t   exp_q[$];
  int     grant_log[$];
  int     lat_log[$];
  int     resp_cnt[N];
  int     g0[N];
  int     vecs = 0, errs = 0;
  int     cyc = 0, acc_cyc = 0, first_acc = -1, rel_cyc = 0, resp_tot = 0, m_ptr = 0;
  bit     inflight = 0, rand_en = 0, ph0 = 0;
  logic [N-1:0] en = '1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] i2f(input int n);
    int e;
    logic [31:0] m;
    e = 0;
    if (n == 0) return 32'h0;
    for (int k = 0; k < 31; k++) if (n >= (1 << k)) e = k;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  // Exact-quotient operands: a = q*d, b = d, z = q, random sign on a and z.
  function automatic op_t rand_op();
    op_t o;
    int q, d;
    logic s;
    q = int'($urandom_range(1, 2000));
    d = int'($urandom_range(1, 60));
    s = 1'($urandom_range(0, 1));
    o.a = i2f(q * d);
    o.b = i2f(d);
    o.z = i2f(q);
    o.a[31] = s;
    o.z[31] = s;
    return o;
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
    op_t o;
    o.a = a; o.b = b; o.z = z;
    return o;
  endfunction

  // Spec rule: first valid requester starting from the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic bit pend_any();
    for (int i = 0; i < N; i++) if (pend[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rand_en) en[i] = ($urandom_range(0, 2) != 0);
      req_valid[i] = en[i] && (pend[i].size() > 0);
      if (pend[i].size() > 0) begin
        req_a[32*i +: 32] = pend[i][0].a;
        req_b[32*i +: 32] = pend[i][0].b;
      end
    end
  end

  always @(negedge clk) begin
    int w, id;
    logic [N-1:0] er;
    exp_t e;
    if (rst) begin
      check("rst_ready", 32'(req_ready), 32'h0);
      exp_q.delete();
      inflight  = 0;
      m_ptr     = 0;
      first_acc = -1;
    end else begin
      check("busy", 32'(busy), 32'(inflight && resp_valid == '0 && req_ready == '0));
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) check("unexpected_resp", 32'(resp_valid), 32'h0);
        else begin
          e = exp_q.pop_front();
          er = '0; er[e.id] = 1'b1;
          check("resp_onehot", 32'(resp_valid), 32'(er));
          check("resp_id", 32'(resp_id), 32'(e.id));
          check("resp_z", resp_z, e.z);
          resp_cnt[e.id]++;
          resp_tot++;
          lat_log.push_back(cyc - acc_cyc);
        end
        inflight = 0;
      end
      if (inflight) check("ready_in_flight", 32'(req_ready), 32'h0);
      else if (resp_valid != '0 || req_ready != '0) begin
        w = model_pick(req_valid, m_ptr);
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        check("grant", 32'(req_ready), 32'(er));
      end
      if (req_ready != '0) begin
        id = 0;
        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) id = i;
        if (pend[id].size() == 0) check("grant_empty", 32'h1, 32'h0);
        else begin
          e.id = id;
          e.z  = pend[id][0].z;
          exp_q.push_back(e);
          void'(pend[id].pop_front());
        end
        m_ptr    = (id + 1) % N;
        inflight = 1;
        acc_cyc  = cyc;
        if (first_acc < 0) first_acc = cyc;
        grant_log.push_back(id);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ph0) begin
      if (req_ready0 != '0) begin
        check("rr0_grant", 32'(req_ready0), 32'h1);
        for (int i = 0; i < N; i++) if (req_ready0[i]) g0[i]++;
      end
      if (resp_valid0 != '0) begin
        check("rr0_resp_id", 32'(resp_id0), 32'h0);
        check("rr0_resp_z", resp_z0, 32'h4000_0000);
      end
    end
  end

  task automatic rst_on();
    @(posedge clk); #2 rst = 1'b1;
  endtask

  task automatic rst_off();
    @(posedge clk); #2 rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_idle(input int lim);
    int t;
    t = 0;
    while ((pend_any() || exp_q.size() > 0 || inflight) && t < lim) begin
      @(posedge clk);
      t++;
    end
    check("idle_timeout", 32'(t >= lim), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    req_valid0 = '0; req_a0 = '0; req_b0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_resp_z", resp_z, 32'h0);
    check("reset_resp_id", 32'(resp_id), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Single requester, repeated op: first-slot grant and stable latency.
    pend[0].push_back(mk(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000));
    pend[0].push_back(mk(32'h40C0_0000, 32'h4040_0000, 32'h4000_0000));
    rst_off();
    wait_idle(2000);
    check("first_slot_accept", 32'(first_acc), 32'(rel_cyc));
    check("lat_count", 32'(lat_log.size()), 32'd2);
    if (lat_log.size() == 2) begin
      check("lat_repeat", 32'(lat_log[1]), 32'(lat_log[0]));
      check("lat_range", 32'(lat_log[0] >= 100 && lat_log[0] <= 130), 32'h1);
    end

    // Requesters 1 and 3 together straight after reset.
    rst_on();
    pend[1].push_back(mk(32'h3F80_0000, 32'h4080_0000, 32'h3E80_0000));
    pend[3].push_back(mk(32'h4110_0000, 32'h4040_0000, 32'h4040_0000));
    rst_off();
    wait_idle(2000);
    n = grant_log.size();
    check("pair_first", 32'(grant_log[n-2]), 32'd1);
    check("pair_second", 32'(grant_log[n-1]), 32'd3);

    // All four continuously valid for eight operations.
    rst_on();
    for (int i = 0; i < N; i++) begin
      resp_cnt[i] = 0;
      pend[i].push_back(rand_op());
      pend[i].push_back(rand_op());
    end
    rst_off();
    wait_idle(4000);
    n = grant_log.size();
    for (int k = 0; k < 8; k++) check("rotation", 32'(grant_log[n-8+k]), 32'(k % N));
    for (int i = 0; i < N; i++) check("per_req_count", 32'(resp_cnt[i]), 32'd2);

    // Special operands and one inexact quotient.
    pend[0].push_back(mk(FP_ONE, FP_ZERO, FP_PINF));
    wait_idle(2000);
    pend[2].push_back(mk(FP_ZERO, FP_ZERO, FP_QNAN));
    wait_idle(2000);
    pend[1].push_back(mk(FP_ONE, 32'h4040_0000, 32'h3EAA_AAAB));
    wait_idle(2000);

    // Idle gap: dummy slots must stay silent.
    base = resp_tot;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("idle_no_resp", 32'(resp_tot), 32'(base));

    // Reset mid-operation discards the in-flight result.
    pend[0].push_back(mk(32'h40A0_0000, 32'h4000_0000, 32'h4020_0000));
    n = 0;
    while (pend[0].size() > 0 && n < 500) begin @(posedge clk); n++; end
    check("accept_timeout", 32'(n >= 500), 32'h0);
    repeat (30) @(posedge clk);
    base = resp_tot;
    #2 rst = 1'b1;
    pend[0].push_back(mk(32'h40A0_0000, 32'h4000_0000, 32'h4020_0000));
    rst_off();
    wait_idle(2000);
    check("post_rst_accept", 32'(first_acc), 32'(rel_cyc));
    check("post_rst_resp_count", 32'(resp_tot), 32'(base + 1));

    // Randomised traffic with requesters dropping valid before grant.
    rand_en = 1;
    for (int k = 0; k < 40; k++) begin
      pend[$urandom_range(0, N-1)].push_back(rand_op());
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    wait_idle(20000);
    rand_en = 0;
    en = '1;

    // Fixed-priority instance: requester 0 starves requester 2.
    ph0 = 1;
    req_a0[31:0]  = 32'h40C0_0000; req_b0[31:0]  = 32'h4040_0000;
    req_a0[95:64] = 32'h4110_0000; req_b0[95:64] = 32'h4040_0000;
    req_valid0 = 4'b0101;
    n = 0;
    while (g0[0] + g0[2] < 6 && n < 3000) begin @(posedge clk); n++; end
    check("rr0_timeout", 32'(n >= 3000), 32'h0);
    check("rr0_req0_grants", 32'(g0[0]), 32'd6);
    check("rr0_req2_grants", 32'(g0[2]), 32'd0);
    req_valid0 = '0;
    ph0 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
